// File: rtl/axi_wr_burst_arbiter.sv
// Write-path arbiter for a three-master crossbar slave port: round-robin AW grant,
// held through the address handshake and the whole W burst so W beats never interleave.
module axi_wr_burst_arbiter #(
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         m_awvalid,
    input  logic [3*LEN_W-1:0] m_awlen,
    output logic [2:0]         m_awready,
    input  logic [2:0]         m_wvalid,
    input  logic [2:0]         m_wlast,
    output logic [2:0]         m_wready,
    output logic               s_awvalid,
    input  logic               s_awready,
    output logic               s_wvalid,
    output logic               s_wlast,
    input  logic               s_wready,
    output logic [2:0]         grant,
    output logic               busy,
    output logic               len_err
);

    // state | meaning
    // IDLE  | no grant; pick a round-robin winner when any master requests
    // ADDR  | grant held; AW handshake passed through for the granted master
    // DATA  | grant held; W beats counted until beat_cnt == len_q
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state, state_nx;
    logic [2:0]        grant_nx, last_winner, last_winner_nx, winner;
    logic [LEN_W-1:0]  len_q, len_nx, beat_cnt, beat_nx, sel_len;
    logic              len_err_nx;
    logic              g_awvalid, g_wvalid, g_wlast, at_last, w_hs;

    assign g_awvalid = |(m_awvalid & grant);
    assign g_wvalid  = |(m_wvalid & grant);
    assign g_wlast   = |(m_wlast & grant);
    assign at_last   = (beat_cnt == len_q);
    assign w_hs      = g_wvalid & s_wready;
    assign busy      = (state != IDLE);

    // Search starts one past the previous winner; an empty last_winner behaves like master 2.
    always_comb begin
        winner = 3'b000;
        case (last_winner)
            3'b001: begin
                if (m_awvalid[1])      winner = 3'b010;
                else if (m_awvalid[2]) winner = 3'b100;
                else if (m_awvalid[0]) winner = 3'b001;
            end
            3'b010: begin
                if (m_awvalid[2])      winner = 3'b100;
                else if (m_awvalid[0]) winner = 3'b001;
                else if (m_awvalid[1]) winner = 3'b010;
            end
            default: begin
                if (m_awvalid[0])      winner = 3'b001;
                else if (m_awvalid[1]) winner = 3'b010;
                else if (m_awvalid[2]) winner = 3'b100;
            end
        endcase
    end

    always_comb begin
        sel_len = '0;
        for (int i = 0; i < 3; i++) begin
            if (winner[i]) sel_len = m_awlen[i*LEN_W +: LEN_W];
        end
    end

    always_comb begin
        state_nx       = state;
        grant_nx       = grant;
        last_winner_nx = last_winner;
        len_nx         = len_q;
        beat_nx        = beat_cnt;
        len_err_nx     = 1'b0;
        s_awvalid      = 1'b0;
        s_wvalid       = 1'b0;
        s_wlast        = 1'b0;
        m_awready      = 3'b000;
        m_wready       = 3'b000;
        case (state)
            IDLE: begin
                if (|m_awvalid) begin
                    grant_nx = winner;
                    len_nx   = sel_len;
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                s_awvalid = g_awvalid;
                m_awready = grant & {3{s_awready}};
                if (g_awvalid && s_awready) begin
                    beat_nx  = '0;
                    state_nx = DATA;
                end
            end
            DATA: begin
                s_wvalid = g_wvalid;
                s_wlast  = at_last & g_wvalid;
                m_wready = grant & {3{s_wready}};
                if (w_hs) begin
                    beat_nx    = beat_cnt + 1'b1;
                    len_err_nx = (g_wlast != at_last);
                    // Terminate on the compare, before the counter could wrap.
                    if (at_last) begin
                        last_winner_nx = grant;
                        grant_nx       = 3'b000;
                        state_nx       = IDLE;
                    end
                end
            end
            default: begin
                grant_nx = 3'b000;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 3'b000;
            last_winner <= 3'b000;
            len_q       <= '0;
            beat_cnt    <= '0;
            len_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            last_winner <= last_winner_nx;
            len_q       <= len_nx;
            beat_cnt    <= beat_nx;
            len_err     <= len_err_nx;
        end
    end

endmodule
